hello_mpf_line_writer: RTL and testbench

Multi-line write engine that replaces the single-line "Hello world!" writer. On a start pulse from the CSR decode logic, it issues `num_lines` consecutive cache-line writes starting at `base_addr` on the MPF c1 TX channel. It then counts write responses returning on c1 RX and pulses `done` once every line is acknowledged. It sits between the app CSR block (upstream) and the `cci_mpf_if` c1 channels (downstream).

---
 rtl/hello_mpf_line_writer_pkg.sv | 30 +++
 rtl/hello_mpf_wr_rsp_counter.sv | 51 +++++
 rtl/hello_mpf_line_writer.sv | 157 +++++++++++++++
 tb/tb_hello_mpf_line_writer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hello_mpf_line_writer_pkg.sv
// Shared types and the line payload generator for the multi-line MPF writer.
package hello_mpf_line_writer_pkg;

    localparam int LINE_CNT_W = 16;
    localparam int LINE_W     = 512;
    localparam int LANE_W     = 64;
    localparam int N_LANES    = LINE_W / LANE_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } t_state;

    typedef logic [LINE_CNT_W-1:0] t_line_cnt;
    typedef logic [LINE_W-1:0]     t_line_data;

    // Every 64-bit lane carries seed + line index (mod 2^64); lane 0 is the low word.
    function automatic t_line_data gen_line_data(input logic [63:0] seed, input logic [63:0] idx);
        t_line_data    data;
        logic [63:0]   lane;
        lane = seed + idx;
        for (int i = 0; i < N_LANES; i++) begin
            data[i*LANE_W +: LANE_W] = lane;
        end
        return data;
    endfunction

endpackage

// File: rtl/hello_mpf_wr_rsp_counter.sv
// Counts c1 write responses against lines issued; flags responses with nothing outstanding.
module hello_mpf_wr_rsp_counter
    import hello_mpf_line_writer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [CNT_W-1:0] issued,
    input  logic             c1Rx_wrRsp,
    output logic [CNT_W-1:0] lines_acked,
    output logic             err_unexp_rsp
);

    logic [CNT_W-1:0] acked_q, acked_d;
    logic             err_q,   err_d;

    // Next-state: clear from a new run wins over a response in the same cycle.
    always_comb begin
        acked_d = acked_q;
        err_d   = err_q;
        if (clear) begin
            acked_d = {CNT_W{1'b0}};
            err_d   = 1'b0;
        end else if (c1Rx_wrRsp) begin
            if (acked_q < issued) begin
                acked_d = acked_q + CNT_W'(1);
            end else begin
                err_d = 1'b1;
            end
        end else begin
            acked_d = acked_q;
        end
    end

    // Response count and sticky error registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acked_q <= {CNT_W{1'b0}};
            err_q   <= 1'b0;
        end else begin
            acked_q <= acked_d;
            err_q   <= err_d;
        end
    end

    assign lines_acked   = acked_q;
    assign err_unexp_rsp = err_q;

endmodule

// File: rtl/hello_mpf_line_writer.sv
// Multi-line cache write engine: issues num_lines writes on c1 TX, then waits for all acks.
module hello_mpf_line_writer
    import hello_mpf_line_writer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [41:0]      base_addr,
    input  logic [CNT_W-1:0] num_lines,
    input  logic [63:0]      seed,
    input  logic             c1TxAlmFull,
    output logic             c1Tx_valid,
    output logic [41:0]      c1Tx_addr,
    output logic [15:0]      c1Tx_mdata,
    output logic [511:0]     c1Tx_data,
    input  logic             c1Rx_wrRsp,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] lines_acked,
    output logic             err_unexp_rsp
);

    t_state           state_q,  state_d;
    logic [41:0]      base_q,   base_d;
    logic [CNT_W-1:0] num_q,    num_d;
    logic [63:0]      seed_q,   seed_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic             valid_q,  valid_d;
    logic [41:0]      addr_q,   addr_d;
    logic [15:0]      mdata_q,  mdata_d;
    t_line_data       data_q,   data_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             clear_s;
    logic [CNT_W-1:0] issued_inc_s;
    logic [CNT_W-1:0] lines_acked_s;
    logic             err_s;

    hello_mpf_wr_rsp_counter #(.CNT_W(CNT_W)) u_rsp_counter (
        .clk           (clk),
        .reset_n       (reset_n),
        .clear         (clear_s),
        .issued        (issued_q),
        .c1Rx_wrRsp    (c1Rx_wrRsp),
        .lines_acked   (lines_acked_s),
        .err_unexp_rsp (err_s)
    );

    // FSM next-state and request generation; AlmFull only reaches registers.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        num_d        = num_q;
        seed_d       = seed_q;
        issued_d     = issued_q;
        valid_d      = 1'b0;
        addr_d       = addr_q;
        mdata_d      = mdata_q;
        data_d       = data_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        clear_s      = 1'b0;
        issued_inc_s = issued_q + CNT_W'(1);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d   = base_addr;
                    num_d    = num_lines;
                    seed_d   = seed;
                    issued_d = {CNT_W{1'b0}};
                    clear_s  = 1'b1;
                    busy_d   = 1'b1;
                    if (num_lines == {CNT_W{1'b0}}) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (!c1TxAlmFull && (issued_q < num_q)) begin
                    valid_d  = 1'b1;
                    addr_d   = base_q + 42'(issued_q);
                    mdata_d  = 16'(issued_q);
                    data_d   = gen_line_data(seed_q, 64'(issued_q));
                    issued_d = issued_inc_s;
                    if (issued_inc_s == num_q) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (lines_acked_s == num_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched run parameters and registered request outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            base_q   <= 42'd0;
            num_q    <= {CNT_W{1'b0}};
            seed_q   <= 64'd0;
            issued_q <= {CNT_W{1'b0}};
            valid_q  <= 1'b0;
            addr_q   <= 42'd0;
            mdata_q  <= 16'd0;
            data_q   <= {LINE_W{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            num_q    <= num_d;
            seed_q   <= seed_d;
            issued_q <= issued_d;
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            mdata_q  <= mdata_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign c1Tx_valid    = valid_q;
    assign c1Tx_addr     = addr_q;
    assign c1Tx_mdata    = mdata_q;
    assign c1Tx_data     = data_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign lines_acked   = lines_acked_s;
    assign err_unexp_rsp = err_s;

endmodule

// File: tb/tb_hello_mpf_line_writer.sv
// Scoreboard bench for hello_mpf_line_writer: directed runs, responses looped back 5 cycles later.
module tb_hello_mpf_line_writer;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [41:0]  base_addr;
    logic [15:0]  num_lines;
    logic [63:0]  seed;
    logic         c1TxAlmFull;
    logic         c1Tx_valid;
    logic [41:0]  c1Tx_addr;
    logic [15:0]  c1Tx_mdata;
    logic [511:0] c1Tx_data;
    logic         c1Rx_wrRsp;
    logic         busy;
    logic         done;
    logic [15:0]  lines_acked;
    logic         err_unexp_rsp;

    logic [4:0]   rsp_pipe = 5'd0;
    logic         inj_rsp  = 1'b0;
    int           cyc      = 0;
    int           n_checks = 0;
    int           n_fail   = 0;
    int           done_cnt = 0;
    int           valid_cnt = 0;

    typedef struct {
        logic [41:0] addr;
        logic [15:0] mdata;
        logic [63:0] lane;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    assign c1Rx_wrRsp = rsp_pipe[4] | inj_rsp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hello_mpf_line_writer #(.CNT_W(16)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .base_addr     (base_addr),
        .num_lines     (num_lines),
        .seed          (seed),
        .c1TxAlmFull   (c1TxAlmFull),
        .c1Tx_valid    (c1Tx_valid),
        .c1Tx_addr     (c1Tx_addr),
        .c1Tx_mdata    (c1Tx_mdata),
        .c1Tx_data     (c1Tx_data),
        .c1Rx_wrRsp    (c1Rx_wrRsp),
        .busy          (busy),
        .done          (done),
        .lines_acked   (lines_acked),
        .err_unexp_rsp (err_unexp_rsp)
    );

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: response loopback, done counting, and scoreboard compare of every request.
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [511:0] exp_data;
        rsp_pipe = {rsp_pipe[3:0], c1Tx_valid};
        if (done) done_cnt++;
        if (c1Tx_valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_req: got request addr 0x%0h at cycle %0d, expected none", c1Tx_addr, cyc);
            end else begin
                e = exp_q.pop_front();
                exp_data = {8{e.lane}};
                check("req_addr",  c1Tx_addr,  e.addr);
                check("req_mdata", c1Tx_mdata, e.mdata);
                check("req_data",  c1Tx_data,  exp_data);
                check("req_cycle", cyc,        e.cyc);
            end
        end
    end

    // Issue start in the current cycle (cycle 0) and queue the expected requests.
    task automatic start_run(input logic [41:0] b, input logic [15:0] n, input logic [63:0] s, input int first_off);
        exp_t e;
        base_addr = b;
        num_lines = n;
        seed      = s;
        start     = 1'b1;
        for (int i = 0; i < int'(n); i++) begin
            e.addr  = b + 42'(i);
            e.mdata = 16'(i);
            e.lane  = s + 64'(i);
            e.cyc   = cyc + first_off + i;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", seen, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int v0;
        reset_n     = 1'b0;
        start       = 1'b0;
        base_addr   = 42'd0;
        num_lines   = 16'd0;
        seed        = 64'd0;
        c1TxAlmFull = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", c1Tx_valid, 1'b0);
        check("rst_addr",  c1Tx_addr,  42'd0);
        check("rst_mdata", c1Tx_mdata, 16'd0);
        check("rst_data",  c1Tx_data,  512'd0);
        check("rst_busy",  busy,       1'b0);
        check("rst_done",  done,       1'b0);
        check("rst_acked", lines_acked, 16'd0);
        check("rst_err",   err_unexp_rsp, 1'b0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Four lines, plus a start in cycle 3 that must be ignored.
        d0 = done_cnt; v0 = valid_cnt;
        start_run(42'h1000, 16'd4, 64'h10, 2);
        @(negedge clk); start = 1'b0;
        check("t1_busy_c1", busy, 1'b1);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; base_addr = 42'h9000; num_lines = 16'd7; seed = 64'hAA;
        @(negedge clk); start = 1'b0;
        wait_done(60);
        check("t1_acked", lines_acked, 16'd4);
        check("t1_busy_done", busy, 1'b0);
        check("t1_err", err_unexp_rsp, 1'b0);
        repeat (8) @(negedge clk);
        check("t1_done_pulses", done_cnt - d0, 1);
        check("t1_req_count", valid_cnt - v0, 4);
        check("t1_queue_empty", exp_q.size(), 0);

        // Back-pressure through cycle 6: first request in cycle 8.
        v0 = valid_cnt;
        start_run(42'h2000, 16'd3, 64'h100, 8);
        c1TxAlmFull = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (6) @(negedge clk);
        c1TxAlmFull = 1'b0;
        wait_done(60);
        check("t2_acked", lines_acked, 16'd3);
        repeat (8) @(negedge clk);
        check("t2_req_count", valid_cnt - v0, 3);
        check("t2_queue_empty", exp_q.size(), 0);

        // Address and lane wrap.
        start_run(42'h3FF_FFFF_FFFF, 16'd2, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        @(negedge clk); start = 1'b0;
        wait_done(60);
        check("t3_acked", lines_acked, 16'd2);
        repeat (8) @(negedge clk);
        check("t3_queue_empty", exp_q.size(), 0);

        // Zero lines: done in cycle 2, no requests; then an unexpected response in IDLE.
        d0 = done_cnt; v0 = valid_cnt;
        start_run(42'h5000, 16'd0, 64'h1, 2);
        @(negedge clk); start = 1'b0;
        check("t4_busy_c1", busy, 1'b1);
        check("t4_done_c1", done, 1'b0);
        @(negedge clk);
        check("t4_done_c2", done, 1'b1);
        check("t4_busy_c2", busy, 1'b0);
        @(negedge clk);
        check("t4_done_c3", done, 1'b0);
        repeat (3) @(negedge clk);
        check("t4_req_count", valid_cnt - v0, 0);
        check("t4_done_pulses", done_cnt - d0, 1);
        check("t4_err_before", err_unexp_rsp, 1'b0);
        inj_rsp = 1'b1;
        @(negedge clk); inj_rsp = 1'b0;
        @(negedge clk);
        check("t4_err_idle_rsp", err_unexp_rsp, 1'b1);
        check("t4_acked_idle", lines_acked, 16'd0);

        // Reset after two of eight lines issued.
        v0 = valid_cnt;
        start_run(42'h2_0000, 16'd8, 64'h55, 2);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("t5_issued_before_rst", valid_cnt - v0, 2);
        check("t5_rst_valid", c1Tx_valid, 1'b0);
        check("t5_rst_addr",  c1Tx_addr,  42'd0);
        check("t5_rst_mdata", c1Tx_mdata, 16'd0);
        check("t5_rst_data",  c1Tx_data,  512'd0);
        check("t5_rst_busy",  busy,       1'b0);
        check("t5_rst_done",  done,       1'b0);
        check("t5_rst_acked", lines_acked, 16'd0);
        check("t5_rst_err",   err_unexp_rsp, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("t5_err_late_rsp", err_unexp_rsp, 1'b1);
        check("t5_acked_late", lines_acked, 16'd0);
        check("t5_busy_late", busy, 1'b0);
        repeat (3) @(negedge clk);
        start_run(42'h40, 16'd2, 64'h7, 2);
        @(negedge clk); start = 1'b0;
        wait_done(60);
        check("t5_rerun_acked", lines_acked, 16'd2);
        check("t5_rerun_err", err_unexp_rsp, 1'b0);
        repeat (8) @(negedge clk);
        check("t5_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
